// File: rtl/ethernet_rx.sv
// ethernet_rx
// RMII receive front end for the Ethernet host interface. It deserialises
// dibits from the PHY and locks onto the preamble and SFD. It checks the
// destination MAC and the EtherType, then extracts a 5-byte request payload.
// Each accepted frame produces a one-cycle {rw, addr, data} request for the
// core bus. FCS is not checked, and padding and FCS bytes are discarded.
//
// Parameters
//   FPGA_MAC   accepted destination MAC
//   ETHERTYPE  accepted EtherType
//   MIN_PRE    minimum number of 2'b01 preamble dibits before the SFD
//
// Ports
//   clk      in   50 MHz RMII reference clock, rising edge
//   rst      in   asynchronous active-high reset
//   crsdv    in   RMII carrier-sense / data-valid
//   rxd      in   RMII receive dibit, LSB dibit of each byte first
//   addr_o   out  request address
//   data_o   out  request write data
//   rw_o     out  1 = write, 0 = read
//   valid_o  out  one-cycle request strobe

module ethernet_rx #(
    parameter logic [47:0] FPGA_MAC  = 48'h0,
    parameter logic [15:0] ETHERTYPE = 16'h0,
    parameter int          MIN_PRE   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        crsdv,
    input  logic [1:0]  rxd,
    output logic [15:0] addr_o,
    output logic [15:0] data_o,
    output logic        rw_o,
    output logic        valid_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_HDR,
        S_PAY,
        S_WAIT,
        S_DROP
    } state_t;

    localparam logic [7:0] MIN_PRE_C = 8'(MIN_PRE);

    state_t      state;
    state_t      next_state;

    logic [7:0]  pre_cnt;
    logic [5:0]  cnt;
    logic [5:0]  byte_sr;
    logic [47:0] dst_sr;
    logic [15:0] type_sr;
    logic [23:0] pay_sr;
    logic        rw_bit;

    logic [7:0]  new_byte;
    logic        dst_match;
    logic        pre_clr;
    logic        pre_inc;
    logic        cnt_clr;
    logic        cnt_inc;
    logic        shift_en;
    logic        hdr_push;
    logic        pay_push;
    logic        accept;

    // The byte completed by the dibit currently on rxd. Earlier dibits sit in
    // byte_sr, and the oldest one lands in the low bits.
    assign new_byte  = {rxd, byte_sr};
    assign dst_match = (dst_sr == FPGA_MAC) && (type_sr == ETHERTYPE);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic and datapath controls. Carrier loss in PRE, HDR or PAY
    // aborts the frame at once. The acceptance decision is made on the same
    // cycle the last payload dibit is sampled.
    always_comb begin
        next_state = state;
        pre_clr    = 1'b0;
        pre_inc    = 1'b0;
        cnt_clr    = 1'b0;
        cnt_inc    = 1'b0;
        shift_en   = 1'b0;
        hdr_push   = 1'b0;
        pay_push   = 1'b0;
        accept     = 1'b0;
        case (state)
            S_IDLE: begin
                if (crsdv) begin
                    next_state = S_PRE;
                    pre_clr    = 1'b1;
                end
            end
            S_PRE: begin
                if (!crsdv) begin
                    next_state = S_IDLE;
                end else begin
                    case (rxd)
                        2'b00: begin
                            // Leading zeros before the preamble proper are tolerated
                            if (pre_cnt != 8'd0) begin
                                next_state = S_DROP;
                            end
                        end
                        2'b01: begin
                            pre_inc = 1'b1;
                        end
                        2'b11: begin
                            if (pre_cnt >= MIN_PRE_C) begin
                                next_state = S_HDR;
                                cnt_clr    = 1'b1;
                            end else begin
                                next_state = S_DROP;
                            end
                        end
                        default: begin
                            next_state = S_DROP;
                        end
                    endcase
                end
            end
            S_HDR: begin
                if (!crsdv) begin
                    next_state = S_IDLE;
                end else begin
                    shift_en = 1'b1;
                    hdr_push = (cnt[1:0] == 2'd3);
                    if (cnt == 6'd55) begin
                        next_state = S_PAY;
                        cnt_clr    = 1'b1;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
            end
            S_PAY: begin
                if (!crsdv) begin
                    next_state = S_IDLE;
                end else begin
                    shift_en = 1'b1;
                    pay_push = (cnt[1:0] == 2'd3);
                    if (cnt == 6'd19) begin
                        next_state = S_WAIT;
                        cnt_clr    = 1'b1;
                        accept     = dst_match;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
            end
            S_WAIT, S_DROP: begin
                if (!crsdv) begin
                    next_state = S_IDLE;
                end
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    // Counters, field shift registers and the registered request outputs.
    // Only the header fields that are checked are kept. dst_sr fills from the
    // first six bytes. type_sr keeps the last two header bytes, which are the
    // EtherType once the header ends. pay_sr holds payload bytes 1-3, and the
    // final byte comes straight from new_byte on the accept cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_cnt <= 8'd0;
            cnt     <= 6'd0;
            byte_sr <= 6'd0;
            dst_sr  <= 48'd0;
            type_sr <= 16'd0;
            pay_sr  <= 24'd0;
            rw_bit  <= 1'b0;
            addr_o  <= 16'd0;
            data_o  <= 16'd0;
            rw_o    <= 1'b0;
            valid_o <= 1'b0;
        end else begin
            if (pre_clr) begin
                pre_cnt <= 8'd0;
            end else if (pre_inc && (pre_cnt != 8'hFF)) begin
                pre_cnt <= pre_cnt + 8'd1;
            end

            if (cnt_clr) begin
                cnt <= 6'd0;
            end else if (cnt_inc) begin
                cnt <= cnt + 6'd1;
            end

            if (shift_en) begin
                byte_sr <= {rxd, byte_sr[5:2]};
            end

            if (hdr_push) begin
                type_sr <= {type_sr[7:0], new_byte};
                if (cnt < 6'd24) begin
                    dst_sr <= {dst_sr[39:0], new_byte};
                end
            end

            if (pay_push) begin
                pay_sr <= {pay_sr[15:0], new_byte};
                if (cnt == 6'd3) begin
                    rw_bit <= new_byte[0];
                end
            end

            valid_o <= accept;
            if (accept) begin
                rw_o   <= rw_bit;
                addr_o <= pay_sr[23:8];
                data_o <= {pay_sr[7:0], new_byte};
            end
        end
    end

endmodule

// File: tb/tb_ethernet_rx.sv
// tb_ethernet_rx
// Self-checking bench for ethernet_rx. Frames are built as byte lists, and the
// expected outcome of each frame comes from the frame-level acceptance rules.
// The rules require a long enough clean preamble, a complete payload, no reset,
// and a matching destination MAC and EtherType. Directed frames come first,
// followed by randomly mutated ones.

module tb_ethernet_rx;

    localparam logic [47:0] MAC     = 48'h02_12_34_56_78_9A;
    localparam logic [15:0] ET      = 16'h88B5;
    localparam int          MIN_PRE = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        crsdv;
    logic [1:0]  rxd;
    logic [15:0] addr_o;
    logic [15:0] data_o;
    logic        rw_o;
    logic        valid_o;

    int cmp_cnt   = 0;
    int fail_cnt  = 0;
    int pulse_cnt = 0;

    logic        exp_rw   = 1'b0;
    logic [15:0] exp_addr = 16'd0;
    logic [15:0] exp_data = 16'd0;

    ethernet_rx #(
        .FPGA_MAC (MAC),
        .ETHERTYPE(ET),
        .MIN_PRE  (MIN_PRE)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .crsdv  (crsdv),
        .rxd    (rxd),
        .addr_o (addr_o),
        .data_o (data_o),
        .rw_o   (rw_o),
        .valid_o(valid_o)
    );

    always #10 clk = ~clk;

    // Count strobe cycles. A strobe that lasts two cycles would count twice.
    always @(negedge clk) begin
        if (valid_o === 1'b1) begin
            pulse_cnt++;
        end
    end

    task automatic check_output(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        cmp_cnt++;
        assert (obs === exp) else begin
            fail_cnt++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_held(input string tag);
        check_output({tag, "_rw"},   48'(rw_o),   48'(exp_rw));
        check_output({tag, "_addr"}, 48'(addr_o), 48'(exp_addr));
        check_output({tag, "_data"}, 48'(data_o), 48'(exp_data));
    endtask

    // Sends one frame. abort_bytes >= 0 drops carrier after that many payload
    // bytes. do_reset pulses rst partway through the header.
    task automatic apply_stimulus(
        input logic [47:0] dst,
        input logic [15:0] etype,
        input logic [7:0]  b0,
        input logic [15:0] addr,
        input logic [15:0] data,
        input int          npre,
        input int          lead00,
        input bit          bad_pre,
        input int          abort_bytes,
        input bit          do_reset,
        input int          pad_len,
        input int          gap
    );
        logic [7:0] bytes[$];
        logic [2:0] s[$];
        logic [7:0] b;
        int         hs;
        int         lp;
        int         reset_idx;
        int         start_pulses;
        bit         acc;

        for (int k = 5; k >= 0; k--) bytes.push_back(dst[k*8 +: 8]);
        for (int k = 0; k < 6; k++) bytes.push_back(8'($urandom));
        bytes.push_back(etype[15:8]);
        bytes.push_back(etype[7:0]);
        bytes.push_back(b0);
        bytes.push_back(addr[15:8]);
        bytes.push_back(addr[7:0]);
        bytes.push_back(data[15:8]);
        bytes.push_back(data[7:0]);
        for (int k = 0; k < pad_len + 4; k++) bytes.push_back(8'($urandom));

        s.push_back(3'b100);
        for (int k = 0; k < lead00; k++) s.push_back(3'b100);
        for (int k = 0; k < npre; k++) begin
            if (bad_pre && k == npre / 2) s.push_back(3'b110);
            s.push_back(3'b101);
        end
        s.push_back(3'b111);
        hs = s.size();
        foreach (bytes[n]) begin
            b = bytes[n];
            for (int j = 0; j < 4; j++) s.push_back({1'b1, b[2*j +: 2]});
        end
        lp = hs + 19 * 4 - 1;
        if (abort_bytes >= 0) begin
            while (s.size() > hs + (14 + abort_bytes) * 4) void'(s.pop_back());
        end
        reset_idx = do_reset ? hs + 20 : -1;

        acc = (npre >= MIN_PRE) && !bad_pre && (abort_bytes < 0) && !do_reset &&
              (dst == MAC) && (etype == ET);
        start_pulses = pulse_cnt;

        for (int i = 0; i < s.size(); i++) begin
            @(negedge clk);
            if (i == lp + 1) begin
                check_output("valid_latency", 48'(valid_o), 48'(acc));
                if (acc) begin
                    exp_rw   = b0[0];
                    exp_addr = addr;
                    exp_data = data;
                end
                check_held("on_strobe");
            end
            if (i == reset_idx) begin
                #2;
                rst   = 1'b1;
                crsdv = 1'b0;
                rxd   = 2'b00;
                #1;
                exp_rw   = 1'b0;
                exp_addr = 16'd0;
                exp_data = 16'd0;
                check_output("reset_valid", 48'(valid_o), 48'd0);
                check_held("reset_async");
                @(negedge clk);
                rst = 1'b0;
                break;
            end
            {crsdv, rxd} = s[i];
        end

        repeat (gap) begin
            @(negedge clk);
            crsdv = 1'b0;
            rxd   = 2'b00;
        end
        check_output("pulse_count", 48'(pulse_cnt - start_pulses), acc ? 48'd1 : 48'd0);
        check_held("after_frame");
    endtask

    initial begin
        logic [47:0] r_dst;
        logic [15:0] r_type;
        logic [15:0] r_addr;
        logic [15:0] r_data;
        logic [7:0]  r_b0;
        int          r_npre;
        int          r_bad;
        int          r_abort;
        int          mode;

        rst   = 1'b1;
        crsdv = 1'b0;
        rxd   = 2'b00;
        repeat (3) @(negedge clk);
        check_output("reset_valid_init", 48'(valid_o), 48'd0);
        check_held("reset_init");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        $display("[TB] good read frame");
        apply_stimulus(MAC, ET, 8'h00, 16'h1234, 16'h0000, 28, 0, 0, -1, 0, 46, 3);

        $display("[TB] good write frame");
        apply_stimulus(MAC, ET, 8'h01, 16'h00A5, 16'hBEEF, 28, 1, 0, -1, 0, 10, 3);

        $display("[TB] rejected destination and EtherType");
        apply_stimulus(MAC ^ 48'h1, ET, 8'h00, 16'h5555, 16'h6666, 28, 0, 0, -1, 0, 4, 3);
        apply_stimulus(MAC, 16'h0800, 8'h01, 16'h7777, 16'h8888, 28, 0, 0, -1, 0, 4, 3);

        $display("[TB] aborted frame, short preamble, bad preamble dibit");
        apply_stimulus(MAC, ET, 8'h01, 16'h1111, 16'h2222, 28, 0, 0, 3, 0, 4, 3);
        apply_stimulus(MAC, ET, 8'h01, 16'h3333, 16'h4444, 2, 0, 0, -1, 0, 4, 3);
        apply_stimulus(MAC, ET, 8'h01, 16'h9999, 16'hAAAA, 10, 0, 1, -1, 0, 4, 3);
        apply_stimulus(MAC, ET, 8'h00, 16'hC0DE, 16'hF00D, MIN_PRE, 2, 0, -1, 0, 4, 3);

        $display("[TB] reset mid-header");
        apply_stimulus(MAC, ET, 8'h01, 16'hDEAD, 16'hBEEF, 28, 0, 0, -1, 1, 4, 3);
        apply_stimulus(MAC, ET, 8'h01, 16'h4321, 16'h8765, 28, 0, 0, -1, 0, 4, 3);

        $display("[TB] back-to-back frames");
        apply_stimulus(MAC, ET, 8'h00, 16'h0001, 16'h1010, 28, 0, 0, -1, 0, 2, 1);
        apply_stimulus(MAC, ET, 8'h01, 16'h0002, 16'h2020, 28, 0, 0, -1, 0, 2, 3);

        $display("[TB] randomized frames");
        for (int n = 0; n < 14; n++) begin
            r_dst   = MAC;
            r_type  = ET;
            r_b0    = 8'($urandom);
            r_addr  = 16'($urandom);
            r_data  = 16'($urandom);
            r_npre  = $urandom_range(MIN_PRE, 31);
            r_bad   = 0;
            r_abort = -1;
            mode    = $urandom_range(0, 7);
            case (mode)
                0: r_dst = MAC ^ (48'h1 << $urandom_range(0, 47));
                1: r_type = ET ^ (16'h1 << $urandom_range(0, 15));
                2: r_npre = $urandom_range(0, MIN_PRE - 1);
                3: r_bad = 1;
                4: r_abort = $urandom_range(0, 4);
                default: ;
            endcase
            apply_stimulus(r_dst, r_type, r_b0, r_addr, r_data, r_npre,
                           $urandom_range(0, 2), r_bad[0], r_abort, 0,
                           $urandom_range(0, 8), $urandom_range(1, 4));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
        $finish;
    end

endmodule
